// File: rtl/mac_eval_pkg.sv
// Shared widths, FSM states and saturation limit
// for the MAC error monitor.
package mac_eval_pkg;

  localparam int DEF_BIT_WIDTH = 8;
  localparam int DEF_OUT_WIDTH = 32;
  localparam int DEF_CNT_WIDTH = 32;
  localparam int DEF_ERR_WIDTH = 48;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  localparam logic [DEF_ERR_WIDTH-1:0] ERR_SAT = '1;

endpackage

// File: rtl/mac_exact_ref.sv
// Two-stage exact MAC reference: stage 1 holds exact
// and observed sums, stage 2 holds |diff| and mismatch.
module mac_exact_ref
  import mac_eval_pkg::*;
#(
  parameter int BIT_WIDTH = DEF_BIT_WIDTH,
  parameter int OUT_WIDTH = DEF_OUT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 valid_i,
  input  logic [BIT_WIDTH-1:0] weight_i,
  input  logic [BIT_WIDTH-1:0] inp_i,
  input  logic [OUT_WIDTH-1:0] psum_i,
  input  logic [OUT_WIDTH-1:0] dut_sum_i,
  output logic                 s1_valid_o,
  output logic                 s2_valid_o,
  output logic [OUT_WIDTH:0]   abs_err_o,
  output logic                 mismatch_o
);

  logic [2*BIT_WIDTH-1:0] prod;
  logic [OUT_WIDTH-1:0]   exact_d;
  logic                   s1_v_q;
  logic [OUT_WIDTH-1:0]   s1_exact_q;
  logic [OUT_WIDTH-1:0]   s1_dut_q;
  logic [OUT_WIDTH:0]     diff;
  logic [OUT_WIDTH:0]     abs_d;
  logic                   s2_v_q;
  logic [OUT_WIDTH:0]     s2_abs_q;
  logic                   s2_mis_q;

  assign prod    = weight_i * inp_i;
  assign exact_d = OUT_WIDTH'(prod) + psum_i;

  // Difference is signed OUT_WIDTH+1, so negation never overflows.
  always_comb begin
    diff  = {1'b0, s1_dut_q} - {1'b0, s1_exact_q};
    abs_d = diff[OUT_WIDTH] ? (~diff + 1'b1) : diff;
  end

  // Stage 1: exact result alongside the observed sum.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_v_q     <= 1'b0;
      s1_exact_q <= '0;
      s1_dut_q   <= '0;
    end else begin
      s1_v_q <= valid_i;
      if (valid_i) begin
        s1_exact_q <= exact_d;
        s1_dut_q   <= dut_sum_i;
      end
    end
  end

  // Stage 2: absolute error and mismatch flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_v_q   <= 1'b0;
      s2_abs_q <= '0;
      s2_mis_q <= 1'b0;
    end else begin
      s2_v_q <= s1_v_q;
      if (s1_v_q) begin
        s2_abs_q <= abs_d;
        s2_mis_q <= (s1_dut_q != s1_exact_q);
      end
    end
  end

  assign s1_valid_o = s1_v_q;
  assign s2_valid_o = s2_v_q;
  assign abs_err_o  = s2_abs_q;
  assign mismatch_o = s2_mis_q;

endmodule

// File: rtl/mac_error_monitor.sv
// Run controller and error statistics for checking
// an approximate MAC against its exact result.
module mac_error_monitor
  import mac_eval_pkg::*;
#(
  parameter int BIT_WIDTH = DEF_BIT_WIDTH,
  parameter int OUT_WIDTH = DEF_OUT_WIDTH,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH,
  parameter int ERR_WIDTH = DEF_ERR_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [CNT_WIDTH-1:0] num_samples,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BIT_WIDTH-1:0] weight,
  input  logic [BIT_WIDTH-1:0] inp,
  input  logic [OUT_WIDTH-1:0] partial_sum_in,
  input  logic [OUT_WIDTH-1:0] dut_sum,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_WIDTH-1:0] sample_count,
  output logic [CNT_WIDTH-1:0] err_count,
  output logic [ERR_WIDTH-1:0] sum_abs_err,
  output logic [OUT_WIDTH:0]   max_abs_err
);

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] num_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] err_q;
  logic [ERR_WIDTH-1:0] sum_q;
  logic [OUT_WIDTH:0]   max_q;
  logic                 fire;
  logic                 start_ok;
  logic                 s1_v, s2_v, mis;
  logic [OUT_WIDTH:0]   abs_err;
  logic [ERR_WIDTH:0]   sum_ext;

  assign fire     = in_valid && in_ready;
  assign start_ok = start && (state_q == IDLE || state_q == DONE);
  assign sum_ext  = {1'b0, sum_q} + (ERR_WIDTH+1)'(abs_err);

  mac_exact_ref #(
    .BIT_WIDTH(BIT_WIDTH),
    .OUT_WIDTH(OUT_WIDTH)
  ) u_ref (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_i   (fire),
    .weight_i  (weight),
    .inp_i     (inp),
    .psum_i    (partial_sum_in),
    .dut_sum_i (dut_sum),
    .s1_valid_o(s1_v),
    .s2_valid_o(s2_v),
    .abs_err_o (abs_err),
    .mismatch_o(mis)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state: leave RUN on the edge of the final transfer.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start)
          state_d = (num_samples == '0) ? DRAIN : RUN;
      end
      RUN: begin
        if (fire && (cnt_q + CNT_WIDTH'(1) == num_q))
          state_d = DRAIN;
      end
      DRAIN: begin
        if (!s1_v && !s2_v) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Status outputs decoded from state.
  always_comb begin
    busy     = (state_q == RUN) || (state_q == DRAIN);
    done     = (state_q == DONE);
    in_ready = (state_q == RUN) && (cnt_q < num_q);
  end

  // Run length latch, sample counter and statistics.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      num_q <= '0;
      cnt_q <= '0;
      err_q <= '0;
      sum_q <= '0;
      max_q <= '0;
    end else if (start_ok) begin
      num_q <= num_samples;
      cnt_q <= '0;
      err_q <= '0;
      sum_q <= '0;
      max_q <= '0;
    end else begin
      if (fire) cnt_q <= cnt_q + CNT_WIDTH'(1);
      if (s2_v) begin
        if (mis) err_q <= err_q + CNT_WIDTH'(1);
        sum_q <= sum_ext[ERR_WIDTH] ? '1 : sum_ext[ERR_WIDTH-1:0];
        if (abs_err > max_q) max_q <= abs_err;
      end
    end
  end

  assign sample_count = cnt_q;
  assign err_count    = err_q;
  assign sum_abs_err  = sum_q;
  assign max_abs_err  = max_q;

endmodule

// File: tb/tb_mac_error_monitor.sv
// Randomized and directed checks of mac_error_monitor
// against a transaction-level statistics model.
module tb_mac_error_monitor;

  localparam int BW = 8;
  localparam int OW = 32;
  localparam int CW = 32;
  localparam int EW = 36;
  localparam longint unsigned SAT = (64'd1 << EW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [CW-1:0] num_samples;
  logic          in_valid;
  logic          in_ready;
  logic [BW-1:0] weight;
  logic [BW-1:0] inp;
  logic [OW-1:0] partial_sum_in;
  logic [OW-1:0] dut_sum;
  logic          busy;
  logic          done;
  logic [CW-1:0] sample_count;
  logic [CW-1:0] err_count;
  logic [EW-1:0] sum_abs_err;
  logic [OW:0]   max_abs_err;

  mac_error_monitor #(
    .BIT_WIDTH(BW),
    .OUT_WIDTH(OW),
    .CNT_WIDTH(CW),
    .ERR_WIDTH(EW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .num_samples   (num_samples),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .weight        (weight),
    .inp           (inp),
    .partial_sum_in(partial_sum_in),
    .dut_sum       (dut_sum),
    .busy          (busy),
    .done          (done),
    .sample_count  (sample_count),
    .err_count     (err_count),
    .sum_abs_err   (sum_abs_err),
    .max_abs_err   (max_abs_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc_n  = 0;
  int xfer_edge  = 0;
  int start_edge = 0;

  longint unsigned m_n, m_cnt, m_err, m_sum, m_max;
  bit              m_acc;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  task automatic model_clear();
    m_cnt = 0;
    m_err = 0;
    m_sum = 0;
    m_max = 0;
  endtask

  task automatic check_stats(input string p);
    chk({p, "_cnt"}, sample_count, m_cnt);
    chk({p, "_err"}, err_count, m_err);
    chk({p, "_sum"}, sum_abs_err, m_sum);
    chk({p, "_max"}, max_abs_err, m_max);
  endtask

  task automatic start_run(input int n);
    start       = 1'b1;
    num_samples = CW'(n);
    tick();
    start      = 1'b0;
    start_edge = cyc_n;
    m_n   = longint'(n);
    m_acc = 1'b1;
    model_clear();
  endtask

  task automatic send(input logic [7:0] w, input logic [7:0] i,
                      input logic [31:0] p, input logic [31:0] d,
                      input bit v);
    longint unsigned lw, li, lp, ld, ex, ae;
    bit rdy;
    weight = w; inp = i; partial_sum_in = p; dut_sum = d;
    in_valid = v;
    rdy = m_acc && (m_cnt < m_n);
    chk("in_ready", in_ready, rdy);
    if (v && rdy) begin
      lw = w; li = i; lp = p; ld = d;
      ex = (lw * li + lp) % (64'd1 << 32);
      ae = (ld > ex) ? ld - ex : ex - ld;
      m_cnt++;
      if (ae != 0) m_err++;
      m_sum = (m_sum + ae > SAT) ? SAT : m_sum + ae;
      if (ae > m_max) m_max = ae;
    end
    tick();
    if (v && rdy) xfer_edge = cyc_n;
    in_valid = 1'b0;
  endtask

  task automatic rand_send(input bit big);
    logic [7:0]  w, i;
    logic [31:0] p, ex, d;
    int sel;
    w = 8'($urandom);
    i = 8'($urandom);
    p = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FF00 | 32'($urandom_range(0, 255))
                                    : $urandom;
    ex  = 32'(w * i) + p;
    sel = $urandom_range(0, 3);
    case (sel)
      0:       d = ex;
      1:       d = ex + 32'($urandom_range(1, 300));
      2:       d = ex - 32'($urandom_range(1, 300));
      default: d = $urandom;
    endcase
    if (big) d = ex ^ 32'h8000_0000;
    send(w, i, p, d, big || ($urandom_range(0, 3) != 0));
  endtask

  task automatic finish_run(input string p, input bit zero);
    int k;
    k = 0;
    while (!done && k < 20) begin
      tick();
      k++;
    end
    chk({p, "_done"}, done, 1);
    if (zero) chk({p, "_lat0"}, cyc_n - start_edge, 1);
    else      chk({p, "_lat"}, cyc_n - xfer_edge, 3);
    chk({p, "_busy"}, busy, 0);
    check_stats(p);
    m_acc = 1'b0;
  endtask

  initial begin
    int k;
    rst_n = 1'b0; start = 1'b0; num_samples = '0;
    in_valid = 1'b0; weight = '0; inp = '0;
    partial_sum_in = '0; dut_sum = '0;
    m_n = 0; m_acc = 1'b0;
    model_clear();
    tick();
    tick();
    chk("rst_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    check_stats("rst");
    rst_n = 1'b1;
    tick();

    // Exact tuples, including 32-bit wrap-around.
    start_run(3);
    chk("t1_busy", busy, 1);
    send(8'd3, 8'd4, 32'd10, 32'd22, 1);
    send(8'd255, 8'd255, 32'd0, 32'd65025, 1);
    send(8'd1, 8'd1, 32'hFFFF_FFFF, 32'd0, 1);
    finish_run("t1", 0);
    chk("t1_errc", err_count, 0);

    // Two erroneous tuples, errors +2 and -5.
    start_run(2);
    send(8'd2, 8'd5, 32'd0, 32'd12, 1);
    send(8'd10, 8'd10, 32'd100, 32'd195, 1);
    finish_run("t2", 0);
    chk("t2_sum7", sum_abs_err, 7);
    chk("t2_max5", max_abs_err, 5);

    // Valid held high past the run length.
    start_run(4);
    for (int j = 0; j < 6; j++)
      send(8'(j + 1), 8'(j + 2), 32'(j), 32'(j * 7), 1);
    finish_run("t3", 0);
    chk("t3_cnt4", sample_count, 4);

    // Zero-length run.
    start_run(0);
    chk("t4_ready", in_ready, 0);
    finish_run("t4", 1);

    // Tuples offered while DONE must be ignored.
    for (int j = 0; j < 3; j++) send(8'd9, 8'd9, 32'd0, 32'd1, 1);
    check_stats("idle_in");
    chk("idle_done", done, 1);

    // Reset in the middle of a run.
    start_run(5);
    send(8'd1, 8'd1, 32'd0, 32'd9, 1);
    send(8'd2, 8'd2, 32'd0, 32'd0, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    m_acc = 1'b0; m_n = 0;
    model_clear();
    chk("t5_busy", busy, 0);
    chk("t5_done", done, 0);
    chk("t5_ready", in_ready, 0);
    check_stats("t5a");
    tick();
    tick();
    check_stats("t5b");
    start_run(2);
    rand_send(0); rand_send(0);
    k = 0;
    while (m_cnt < m_n && k < 50) begin rand_send(0); k++; end
    finish_run("t5c", 0);

    // Start pulse during RUN is ignored; in DONE it restarts.
    start_run(3);
    send(8'd4, 8'd4, 32'd0, 32'd20, 1);
    start = 1'b1; num_samples = 32'd7;
    send(8'd5, 8'd5, 32'd0, 32'd25, 1);
    start = 1'b0;
    send(8'd6, 8'd6, 32'd0, 32'd30, 1);
    finish_run("t6a", 0);
    chk("t6a_cnt3", sample_count, 3);
    start_run(4);
    chk("t6_clr_cnt", sample_count, 0);
    chk("t6_clr_err", err_count, 0);
    chk("t6_clr_sum", sum_abs_err, 0);
    chk("t6_clr_max", max_abs_err, 0);
    chk("t6_busy", busy, 1);
    k = 0;
    while (m_cnt < m_n && k < 60) begin rand_send(0); k++; end
    finish_run("t6b", 0);
    chk("t6b_cnt4", sample_count, 4);

    // Saturation of the summed error.
    start_run(40);
    for (int j = 0; j < 40; j++) rand_send(1);
    finish_run("sat", 0);
    chk("sat_val", sum_abs_err, SAT);
    chk("sat_max", max_abs_err, 64'h8000_0000);

    // Random runs.
    for (int r = 0; r < 8; r++) begin
      start_run($urandom_range(1, 12));
      k = 0;
      while (m_cnt < m_n && k < 200) begin rand_send(0); k++; end
      finish_run("rnd", 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule
